// File: rtl/bin_window_3x3.sv
// bin_window_3x3: builds a 3x3 binary neighbourhood from a raster-scanned 1-bit pixel stream.
// Define BIN_WINDOW_BORDER_ZERO_EN to force taps that fall outside the image to 0.
`timescale 1ns/1ps
module bin_window_3x3 #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned COL_W    = 11
) (
  input  logic video_clk,
  input  logic rst,
  input  logic in_vs,
  input  logic in_de,
  input  logic in_bin,
  output logic bin_data_11,
  output logic bin_data_12,
  output logic bin_data_13,
  output logic bin_data_21,
  output logic bin_data_22,
  output logic bin_data_23,
  output logic bin_data_31,
  output logic bin_data_32,
  output logic bin_data_33,
  output logic win_de,
  output logic win_vs
);

  localparam logic [COL_W-1:0] ColLast = COL_W'(H_ACTIVE - 1);

  // Input stage: edge detect, arming, column/line tracking
  logic             vs_q;
  logic             armed_q;
  logic             de_q;
  logic             col_full_q;
  logic [COL_W-1:0] col_cnt_q;
  logic [1:0]       line_cnt_q;

  logic             vs_rise;
  logic             de_eff;
  logic             full_eff;
  logic             wr_en;
  logic [COL_W-1:0] addr;
  logic [1:0]       line_eff;

  // Frame start overrides the running counters for the pixel in the same cycle.
  assign vs_rise  = in_vs & ~vs_q;
  assign de_eff   = in_de & (armed_q | vs_rise);
  assign addr     = vs_rise ? '0 : col_cnt_q;
  assign full_eff = vs_rise ? 1'b0 : col_full_q;
  assign line_eff = vs_rise ? 2'd0 : line_cnt_q;
  assign wr_en    = de_eff & ~full_eff & ~rst;

  always_ff @(posedge video_clk) begin
    if (rst) begin
      vs_q       <= in_vs;
      armed_q    <= 1'b0;
      de_q       <= 1'b0;
      col_cnt_q  <= '0;
      col_full_q <= 1'b0;
      line_cnt_q <= 2'd0;
    end else begin
      vs_q <= in_vs;
      de_q <= de_eff;
      if (vs_rise) begin
        armed_q <= 1'b1;
      end
      if (de_eff) begin
        // col_full marks that address H_ACTIVE-1 has been written this line.
        col_full_q <= full_eff | (addr == ColLast);
        col_cnt_q  <= (addr == ColLast) ? addr : addr + COL_W'(1);
        line_cnt_q <= line_eff;
      end else if (vs_rise) begin
        col_cnt_q  <= '0;
        col_full_q <= 1'b0;
        line_cnt_q <= 2'd0;
      end else if (de_q) begin
        col_cnt_q  <= '0;
        col_full_q <= 1'b0;
        line_cnt_q <= (line_cnt_q == 2'd2) ? 2'd2 : line_cnt_q + 2'd1;
      end
    end
  end

  // Cascaded line buffers, read-before-write, one cycle read latency
  logic buf0_mem [H_ACTIVE];
  logic buf1_mem [H_ACTIVE];
  logic rd0_q;
  logic rd1_q;

  always_ff @(posedge video_clk) begin
    if (de_eff) begin
      rd0_q <= buf0_mem[addr];
      rd1_q <= buf1_mem[addr];
    end
    if (wr_en) begin
      buf0_mem[addr] <= in_bin;
      buf1_mem[addr] <= buf0_mem[addr];
    end
  end

  // Stage 1: align current pixel and controls with the buffer read data
  logic de1_q;
  logic vs1_q;
  logic bin1_q;

  always_ff @(posedge video_clk) begin
    if (rst) begin
      de1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      bin1_q <= 1'b0;
    end else begin
      de1_q  <= de_eff;
      vs1_q  <= in_vs;
      bin1_q <= in_bin;
    end
  end

  logic tap1;
  logic tap2;
  logic tap3;
  logic keep;

`ifdef BIN_WINDOW_BORDER_ZERO_EN
  logic [1:0] line1_q;
  logic       first1_q;
  logic       first_px;

  assign first_px = de_eff & (addr == '0) & ~full_eff;

  always_ff @(posedge video_clk) begin
    if (rst) begin
      line1_q  <= 2'd0;
      first1_q <= 1'b0;
    end else begin
      line1_q  <= line_eff;
      first1_q <= first_px;
    end
  end

  assign tap1 = rd1_q & line1_q[1];
  assign tap2 = rd0_q & (line1_q != 2'd0);
  assign tap3 = bin1_q;
  // Columns x-1/x-2 restart from zero at the first pixel of each line.
  assign keep = ~first1_q;
`else
  assign tap1 = rd1_q;
  assign tap2 = rd0_q;
  assign tap3 = bin1_q;
  assign keep = 1'b1;
`endif

  // Stage 2: window shift registers; bit 2 = x-2, bit 1 = x-1, bit 0 = x
  logic [2:0] row1_q;
  logic [2:0] row2_q;
  logic [2:0] row3_q;
  logic       win_de_q;
  logic       win_vs_q;

  always_ff @(posedge video_clk) begin
    if (rst) begin
      row1_q   <= 3'b000;
      row2_q   <= 3'b000;
      row3_q   <= 3'b000;
      win_de_q <= 1'b0;
      win_vs_q <= 1'b0;
    end else begin
      win_de_q <= de1_q;
      win_vs_q <= vs1_q;
      if (de1_q) begin
        row1_q <= {row1_q[1] & keep, row1_q[0] & keep, tap1};
        row2_q <= {row2_q[1] & keep, row2_q[0] & keep, tap2};
        row3_q <= {row3_q[1] & keep, row3_q[0] & keep, tap3};
      end
    end
  end

  assign bin_data_11 = row1_q[2];
  assign bin_data_12 = row1_q[1];
  assign bin_data_13 = row1_q[0];
  assign bin_data_21 = row2_q[2];
  assign bin_data_22 = row2_q[1];
  assign bin_data_23 = row2_q[0];
  assign bin_data_31 = row3_q[2];
  assign bin_data_32 = row3_q[1];
  assign bin_data_33 = row3_q[0];
  assign win_de      = win_de_q;
  assign win_vs      = win_vs_q;

endmodule

// File: tb/tb_bin_window_3x3.sv
// Directed, table-driven bench for bin_window_3x3 with H_ACTIVE=8.
`timescale 1ns/1ps
module tb_bin_window_3x3;

  localparam int HA  = 8;
  localparam int GAP = 4;

  logic video_clk = 1'b0;
  logic rst;
  logic in_vs;
  logic in_de;
  logic in_bin;
  logic b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic win_de;
  logic win_vs;

  always #5 video_clk = ~video_clk;

  bin_window_3x3 #(
    .H_ACTIVE (8),
    .COL_W    (3)
  ) dut (
    .video_clk   (video_clk),
    .rst         (rst),
    .in_vs       (in_vs),
    .in_de       (in_de),
    .in_bin      (in_bin),
    .bin_data_11 (b11),
    .bin_data_12 (b12),
    .bin_data_13 (b13),
    .bin_data_21 (b21),
    .bin_data_22 (b22),
    .bin_data_23 (b23),
    .bin_data_31 (b31),
    .bin_data_32 (b32),
    .bin_data_33 (b33),
    .win_de      (win_de),
    .win_vs      (win_vs)
  );

  // Window packed as {11,12,13, 21,22,23, 31,32,33}
  logic [8:0] win;
  assign win = {b11, b12, b13, b21, b22, b23, b31, b32, b33};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp,
                       input logic [8:0] mask);
    n_total++;
    if ((act & mask) === (exp & mask)) n_pass++;
    else $display("FAIL %s: got %b, want %b (mask %b)", name, act, exp, mask);
  endtask

  // Monitor: captures each window by (frame, line, col) and checks de/vs latency.
  int         mon_frame    = -1;
  int         mon_line     = 0;
  int         mon_col      = 0;
  int         win_de_count = 0;
  logic       mon_vs_prev  = 1'b0;
  logic       mon_de_prev  = 1'b0;
  logic       lat_en       = 1'b0;
  logic       de_h1 = 1'b0, de_h2 = 1'b0, vs_h1 = 1'b0, vs_h2 = 1'b0;
  logic [8:0] cap     [4][10];
  int         cap_frm [4][10] = '{default: '{default: -2}};

  always @(negedge video_clk) begin
    if (lat_en) begin
      check("win_de_latency", {8'b0, win_de}, {8'b0, de_h2}, 9'h001);
      check("win_vs_latency", {8'b0, win_vs}, {8'b0, vs_h2}, 9'h001);
    end
    de_h2 = de_h1;
    de_h1 = in_de;
    vs_h2 = vs_h1;
    vs_h1 = in_vs;
    if (win_vs && !mon_vs_prev) begin
      mon_frame++;
      mon_line = 0;
      mon_col  = 0;
    end
    if (win_de) begin
      if (mon_line < 4 && mon_col < 10) begin
        cap[mon_line][mon_col]     = win;
        cap_frm[mon_line][mon_col] = mon_frame;
      end
      mon_col++;
      win_de_count++;
    end else if (mon_de_prev) begin
      mon_line++;
      mon_col = 0;
    end
    mon_vs_prev = win_vs;
    mon_de_prev = win_de;
  end

  typedef struct {
    string      name;
    int         frame;
    int         line;
    int         col;
    logic [8:0] mask;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vecs(input int frame);
    foreach (vecs[i]) begin
      if (vecs[i].frame == frame) begin
        if (cap_frm[vecs[i].line][vecs[i].col] != frame) begin
          n_total++;
          $display("FAIL %s: window not captured, frame tag %0d, want %0d", vecs[i].name,
                   cap_frm[vecs[i].line][vecs[i].col], frame);
        end else begin
          check(vecs[i].name, cap[vecs[i].line][vecs[i].col], vecs[i].exp, vecs[i].mask);
        end
      end
    end
  endtask

  // Images: 0 checkerboard, 1 single dot at (1,4), 2 all ones, 3 dot at (0,7), 4 dot at (0,0)
  function automatic logic pix(input int img, input int l, input int c);
    case (img)
      0:       return ((l + c) % 2) == 1;
      1:       return (l == 1) && (c == 4);
      2:       return 1'b1;
      3:       return (l == 0) && (c == 7);
      default: return (l == 0) && (c == 0);
    endcase
  endfunction

  task automatic step(input logic vs, input logic de, input logic b);
    in_vs  = vs;
    in_de  = de;
    in_bin = b;
    @(posedge video_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_line(input int img, input int l, input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b1, pix(img, l, c));
    idle(GAP);
  endtask

  task automatic drive_frame(input int img, input int nlines, input int wide0);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    for (int l = 0; l < nlines; l++) drive_line(img, l, (l == 0) ? wide0 : HA);
    idle(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, want finish before 100000", $time);
    $fatal(1);
  end

  int cnt0;

  initial begin
    vecs.push_back('{"chk_l2c3",   0, 2, 3, 9'h1FF,       9'b101_010_101});
    vecs.push_back('{"chk_l3c7",   0, 3, 7, 9'h1FF,       9'b010_101_010});
    vecs.push_back('{"chk_l1c2",   0, 1, 2, 9'b000_111_111, 9'b000_010_101});
    vecs.push_back('{"dot_b33",    1, 1, 4, 9'b000_111_111, 9'b000_000_001});
    vecs.push_back('{"dot_b32",    1, 1, 5, 9'b000_111_111, 9'b000_000_010});
    vecs.push_back('{"dot_b22",    1, 2, 5, 9'h1FF,       9'b000_010_000});
    vecs.push_back('{"dot_b12",    1, 3, 5, 9'h1FF,       9'b010_000_000});
    vecs.push_back('{"dot_b11",    1, 3, 6, 9'h1FF,       9'b100_000_000});
    vecs.push_back('{"sat_l0c7",   2, 0, 7, 9'b000_000_111, 9'b000_000_001});
    vecs.push_back('{"sat_shift",  2, 0, 9, 9'b000_000_111, 9'b000_000_100});
    vecs.push_back('{"sat_keep7",  2, 1, 7, 9'b000_111_111, 9'b000_001_000});
    vecs.push_back('{"vsde_c0",    3, 0, 0, 9'b000_000_001, 9'b000_000_001});
    vecs.push_back('{"vsde_r2c0",  3, 1, 0, 9'b000_001_000, 9'b000_001_000});
    vecs.push_back('{"vsde_r2c1",  3, 1, 1, 9'b000_011_000, 9'b000_010_000});
    vecs.push_back('{"ones_l2c2",  5, 2, 2, 9'h1FF,       9'h1FF});
    vecs.push_back('{"ones_l2c7",  5, 2, 7, 9'h1FF,       9'h1FF});
`ifdef BIN_WINDOW_BORDER_ZERO_EN
    vecs.push_back('{"bz_vsde_c0", 3, 0, 0, 9'h1FF,       9'b000_000_001});
    vecs.push_back('{"bz_l0c0",    5, 0, 0, 9'h1FF,       9'b000_000_001});
    vecs.push_back('{"bz_l0c1",    5, 0, 1, 9'h1FF,       9'b000_000_011});
    vecs.push_back('{"bz_l1c1",    5, 1, 1, 9'h1FF,       9'b000_011_011});
`else
    // Raw buffer contents left by the frame that was cut short by reset.
    vecs.push_back('{"stale_l0c0", 5, 0, 0, 9'b001_001_001, 9'b000_001_001});
`endif

    rst    = 1'b1;
    in_vs  = 1'b0;
    in_de  = 1'b0;
    in_bin = 1'b0;
    repeat (3) @(posedge video_clk);
    #1;
    check("reset_window", win, 9'h000, 9'h1FF);
    check("reset_win_de", {8'b0, win_de}, 9'h000, 9'h001);
    check("reset_win_vs", {8'b0, win_vs}, 9'h000, 9'h001);
    rst = 1'b0;
    idle(2);
    lat_en = 1'b1;

    drive_frame(0, 4, HA);
    run_vecs(0);
    drive_frame(1, 4, HA);
    run_vecs(1);
    drive_frame(3, 2, 10);
    run_vecs(2);

    // Frame 3: vs rises mid de-run; that pixel must land at column 0, line 0
    idle(2);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < HA; c++) step(1'b1, 1'b1, 1'b0);
    idle(GAP);
    drive_line(4, 1, HA);
    idle(4);
    run_vecs(3);

    // Frame 4: reset for 3 clk during active video, rest of frame must be ignored
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    drive_line(0, 0, HA);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, pix(0, 1, c));
    lat_en = 1'b0;
    rst    = 1'b1;
    for (int c = 3; c < 6; c++) step(1'b0, 1'b1, pix(0, 1, c));
    check("midrst_window", win, 9'h000, 9'h1FF);
    check("midrst_win_de", {8'b0, win_de}, 9'h000, 9'h001);
    check("midrst_win_vs", {8'b0, win_vs}, 9'h000, 9'h001);
    cnt0 = win_de_count;
    rst  = 1'b0;
    for (int c = 6; c < HA; c++) step(1'b0, 1'b1, pix(0, 1, c));
    idle(GAP);
    drive_line(0, 2, HA);
    drive_line(0, 3, HA);
    idle(4);
    check("unarmed_win_de_count", 9'(win_de_count - cnt0), 9'h000, 9'h1FF);

    // Frame 5: all ones after re-arming
    lat_en = 1'b1;
    drive_frame(2, 3, HA);
    run_vecs(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
